// File: rtl/neuron_mac_seq.sv
// Sequential neuron: walks input/weight RAMs in lockstep, multiply-accumulates onto a bias
// in signed fixed point, then applies ReLU or saturation and offers the result on valid/ready.
module neuron_mac_seq #(
    parameter int unsigned D_WIDTH   = 16,
    parameter int unsigned A_WIDTH   = 4,
    parameter int unsigned FRAC_BITS = 8,
    parameter bit          ACT_RELU  = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [A_WIDTH:0]   n_inputs,
    input  logic [D_WIDTH-1:0] bias,
    output logic [A_WIDTH-1:0] r_addr,
    input  logic [D_WIDTH-1:0] in_data,
    input  logic [D_WIDTH-1:0] w_data,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] out_data
);

    localparam int unsigned AccW = 2 * D_WIDTH + A_WIDTH + 1;
    localparam int unsigned LenW = A_WIDTH + 1;
    localparam logic [LenW-1:0] MaxLen = {1'b1, {A_WIDTH{1'b0}}};
    localparam logic signed [AccW-1:0] MaxVal = {{(AccW-D_WIDTH+1){1'b0}}, {(D_WIDTH-1){1'b1}}};
    localparam logic signed [AccW-1:0] MinVal =
        ACT_RELU ? '0 : {{(AccW-D_WIDTH+1){1'b1}}, {(D_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StRun, StDrain, StSat, StOut} state_e;

    state_e state_q, state_d;

    logic        [LenW-1:0]      len_q, len_d, count_q;
    logic signed [AccW-1:0]      acc_q;
    logic signed [2*D_WIDTH-1:0] in_ext, w_ext, product;
    logic signed [AccW-1:0]      product_ext, bias_ext, shifted;
    logic        [D_WIDTH-1:0]   sat_val;

    assign len_d = (n_inputs > MaxLen) ? MaxLen : n_inputs;

    // Operands are sign-extended first so the product is exact at full width.
    assign in_ext      = {{D_WIDTH{in_data[D_WIDTH-1]}}, in_data};
    assign w_ext       = {{D_WIDTH{w_data[D_WIDTH-1]}}, w_data};
    assign product     = in_ext * w_ext;
    assign product_ext = {{(AccW-2*D_WIDTH){product[2*D_WIDTH-1]}}, product};
    assign bias_ext    = {{(AccW-D_WIDTH){bias[D_WIDTH-1]}}, bias} <<< FRAC_BITS;
    assign shifted     = acc_q >>> FRAC_BITS;

    always_comb begin
        sat_val = shifted[D_WIDTH-1:0];
        if (shifted > MaxVal) begin
            sat_val = MaxVal[D_WIDTH-1:0];
        end else if (shifted < MinVal) begin
            sat_val = MinVal[D_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = (len_d != '0) ? StRun : StSat;
            StRun:   if (count_q == len_q - 1'b1) state_d = StDrain;
            StDrain: state_d = StSat;
            StSat:   state_d = StOut;
            StOut:   if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q     <= '0;
            count_q   <= '0;
            acc_q     <= '0;
            r_addr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        len_q   <= len_d;
                        acc_q   <= bias_ext;
                        count_q <= '0;
                        if (len_d != '0) r_addr <= '0;
                    end
                end
                StRun: begin
                    count_q <= count_q + 1'b1;
                    // RAM data lags the address by one cycle, so the first RUN cycle has none.
                    if (count_q != '0) acc_q <= acc_q + product_ext;
                    if (count_q != len_q - 1'b1) r_addr <= count_q[A_WIDTH-1:0] + 1'b1;
                end
                StDrain: acc_q <= acc_q + product_ext;
                StSat: begin
                    out_data  <= sat_val;
                    out_valid <= 1'b1;
                end
                StOut: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign busy = (state_q != StIdle);

endmodule
